// File: rtl/mac_dot_seq_if.sv
// MAC-side handshake bundle: the sequencer drives operands and the en request,
// the MAC answers with done and its result.
interface mac_dot_seq_if #(
    parameter int A_BITWIDTH   = 8,
    parameter int OUT_BITWIDTH = 20,
    parameter int C_BITWIDTH   = OUT_BITWIDTH - 1
);
    logic                           mac_en;
    logic                           mac_add;
    logic signed [A_BITWIDTH-1:0]   mac_data_a;
    logic signed [A_BITWIDTH-1:0]   mac_data_b;
    logic signed [C_BITWIDTH-1:0]   mac_data_c;
    logic                           mac_done;
    logic signed [OUT_BITWIDTH-1:0] mac_out;

    // Sequencer side (initiator of the en/done handshake)
    modport master (
        output mac_en, mac_add, mac_data_a, mac_data_b, mac_data_c,
        input  mac_done, mac_out
    );

    // MAC side (responder)
    modport slave (
        input  mac_en, mac_add, mac_data_a, mac_data_b, mac_data_c,
        output mac_done, mac_out
    );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: walks a VEC_LEN operand buffer through one external
// MAC, feeding every partial sum back as the next addend (clipped to the addend
// width), and returns bias + sum(a[i]*b[i]) on the result port.
module mac_dot_seq #(
    parameter int A_BITWIDTH   = 8,
    parameter int OUT_BITWIDTH = 20,
    parameter int C_BITWIDTH   = OUT_BITWIDTH - 1,
    parameter int VEC_LEN      = 4,
    parameter int IDX_W        = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic signed [A_BITWIDTH-1:0]   wr_a,
    input  logic signed [A_BITWIDTH-1:0]   wr_b,
    input  logic signed [C_BITWIDTH-1:0]   bias,
    input  logic                           start,
    output logic                           busy,
    output logic                           result_valid,
    output logic signed [OUT_BITWIDTH-1:0] result,
    output logic                           sat,
    output logic                           err,
    mac_dot_seq_if.master                  mac
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(VEC_LEN - 1);

    // Addend range expressed at MAC output width so the compare is sign-correct
    localparam logic signed [OUT_BITWIDTH-1:0] C_MAX = OUT_BITWIDTH'(2 ** (C_BITWIDTH - 1) - 1);
    localparam logic signed [OUT_BITWIDTH-1:0] C_MIN = ~C_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_FINISH
    } state_t;

    state_t                         state_reg;
    logic [IDX_W-1:0]               idx_reg;
    logic [TIMER_W-1:0]             timer_reg;
    logic signed [C_BITWIDTH-1:0]   addend_reg;
    logic signed [OUT_BITWIDTH-1:0] acc_reg;
    logic                           busy_reg;
    logic                           result_valid_reg;
    logic signed [OUT_BITWIDTH-1:0] result_reg;
    logic                           sat_reg;
    logic                           err_reg;
    logic                           mac_en_reg;
    logic signed [A_BITWIDTH-1:0]   data_a_reg;
    logic signed [A_BITWIDTH-1:0]   data_b_reg;
    logic signed [C_BITWIDTH-1:0]   data_c_reg;

    logic signed [A_BITWIDTH-1:0]   op_a_reg [VEC_LEN];
    logic signed [A_BITWIDTH-1:0]   op_b_reg [VEC_LEN];
    logic [VEC_LEN-1:0]             slot_wr;

    logic [IDX_W-1:0]               fetch_idx;
    logic signed [A_BITWIDTH-1:0]   fetch_a;
    logic signed [A_BITWIDTH-1:0]   fetch_b;
    logic                           clip_hi;
    logic                           clip_lo;
    logic signed [C_BITWIDTH-1:0]   addend_next;

    // Per-slot write strobes; out-of-range indices match no slot and are dropped
    generate
        for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_slot_wr
            assign slot_wr[gi] = (state_reg == S_IDLE) && wr_en && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    // Operand buffer: written only while idle, cleared by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                op_a_reg[i] <= '0;
                op_b_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VEC_LEN; i++) begin
                if (slot_wr[i]) begin
                    op_a_reg[i] <= wr_a;
                    op_b_reg[i] <= wr_b;
                end
            end
        end
    end

    // Operands for the next issue; a write coinciding with start is forwarded
    always_comb begin
        fetch_idx = (state_reg == S_IDLE) ? '0 : idx_reg + IDX_W'(1);
        fetch_a   = '0;
        fetch_b   = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (fetch_idx == IDX_W'(i)) begin
                fetch_a = op_a_reg[i];
                fetch_b = op_b_reg[i];
            end
        end
        if (state_reg == S_IDLE && wr_en && wr_idx == '0) begin
            fetch_a = wr_a;
            fetch_b = wr_b;
        end
    end

    // Clip the MAC result into the addend range before feeding it back
    always_comb begin
        clip_hi = mac.mac_out > C_MAX;
        clip_lo = mac.mac_out < C_MIN;
        if (clip_hi) begin
            addend_next = C_MAX[C_BITWIDTH-1:0];
        end else if (clip_lo) begin
            addend_next = C_MIN[C_BITWIDTH-1:0];
        end else begin
            addend_next = mac.mac_out[C_BITWIDTH-1:0];
        end
    end

    // Sequencer FSM with registered MAC-side and result outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= S_IDLE;
            idx_reg          <= '0;
            timer_reg        <= '0;
            addend_reg       <= '0;
            acc_reg          <= '0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            result_reg       <= '0;
            sat_reg          <= 1'b0;
            err_reg          <= 1'b0;
            mac_en_reg       <= 1'b0;
            data_a_reg       <= '0;
            data_b_reg       <= '0;
            data_c_reg       <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        addend_reg <= bias;
                        acc_reg    <= '0;
                        idx_reg    <= '0;
                        timer_reg  <= '0;
                        sat_reg    <= 1'b0;
                        err_reg    <= 1'b0;
                        busy_reg   <= 1'b1;
                        mac_en_reg <= 1'b1;
                        data_a_reg <= fetch_a;
                        data_b_reg <= fetch_b;
                        data_c_reg <= bias;
                        state_reg  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mac.mac_done) begin
                        acc_reg    <= mac.mac_out;
                        addend_reg <= addend_next;
                        if (clip_hi || clip_lo) begin
                            sat_reg <= 1'b1;
                        end
                        mac_en_reg <= 1'b0;
                        timer_reg  <= '0;
                        state_reg  <= S_RELEASE;
                    end else if (timer_reg == TIMER_LAST) begin
                        mac_en_reg       <= 1'b0;
                        err_reg          <= 1'b1;
                        result_reg       <= acc_reg;
                        result_valid_reg <= 1'b1;
                        state_reg        <= S_FINISH;
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (!mac.mac_done) begin
                        if (idx_reg == IDX_LAST) begin
                            result_reg       <= acc_reg;
                            result_valid_reg <= 1'b1;
                            state_reg        <= S_FINISH;
                        end else begin
                            idx_reg    <= idx_reg + IDX_W'(1);
                            timer_reg  <= '0;
                            mac_en_reg <= 1'b1;
                            data_a_reg <= fetch_a;
                            data_b_reg <= fetch_b;
                            data_c_reg <= addend_reg;
                            state_reg  <= S_ISSUE;
                        end
                    end else if (timer_reg == TIMER_LAST) begin
                        err_reg          <= 1'b1;
                        result_reg       <= acc_reg;
                        result_valid_reg <= 1'b1;
                        state_reg        <= S_FINISH;
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                S_FINISH: begin
                    // result_valid cycle: busy still high here, drops next cycle
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_reg;
    assign result_valid   = result_valid_reg;
    assign result         = result_reg;
    assign sat            = sat_reg;
    assign err            = err_reg;
    assign mac.mac_en     = mac_en_reg;
    assign mac.mac_add    = 1'b0;
    assign mac.mac_data_a = data_a_reg;
    assign mac.mac_data_b = data_b_reg;
    assign mac.mac_data_c = data_c_reg;

endmodule
